// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the 7-segment scan driver and the nibble mux
// that feeds it.
package seg7_scan_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Digit select codes; the external nibble mux decodes the same values.
    localparam logic [2:0] SEL_A_LO = 3'd0;
    localparam logic [2:0] SEL_A_HI = 3'd1;
    localparam logic [2:0] SEL_B_LO = 3'd2;
    localparam logic [2:0] SEL_B_HI = 3'd3;
    localparam logic [2:0] SEL_F_LO = 3'd4;
    localparam logic [2:0] SEL_F_HI = 3'd5;

    localparam int NUM_NIBBLES = 6;

endpackage

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: walks decod_sel over the digits, blanks
// between digits, and drives shared segments plus a one-hot digit enable.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_NIBBLES,
    parameter int SEL_WIDTH    = 3,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  scan_en,
    input  logic                  hold,
    input  logic [7:0]            seg_in,
    output logic [SEL_WIDTH-1:0]  decod_sel,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]     BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_WIDTH-1:0] IDX_LAST   = SEL_WIDTH'(NUM_DIGITS - 1);

    if (BLANK_CYCLES < 2) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK_CYCLES must be >= 2");
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("seg7_scan_driver: DWELL_CYCLES must be >= 1");
    end
    if ((2 ** SEL_WIDTH) < NUM_DIGITS) begin : g_bad_sel
        $error("seg7_scan_driver: SEL_WIDTH too narrow for NUM_DIGITS");
    end

    scan_state_t           state_reg, state_next;
    logic [SEL_WIDTH-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [7:0]            seg_out_reg, seg_out_next;
    logic [NUM_DIGITS-1:0] digit_en_reg, digit_en_next;
    logic                  frame_tick_reg, frame_tick_next;
    logic [NUM_DIGITS-1:0] idx_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
            assign idx_onehot[gi] = (idx_reg == SEL_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        seg_out_next    = seg_out_reg;
        digit_en_next   = digit_en_reg;
        frame_tick_next = 1'b0;

        if (!scan_en) begin
            // Abort from any state; a partial frame never ticks.
            state_next    = IDLE;
            idx_next      = '0;
            cnt_next      = '0;
            seg_out_next  = '0;
            digit_en_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    seg_out_next  = '0;
                    digit_en_next = '0;
                    idx_next      = '0;
                    cnt_next      = '0;
                    state_next    = BLANK;
                end
                BLANK: begin
                    seg_out_next  = '0;
                    digit_en_next = '0;
                    if (cnt_reg == BLANK_LAST) begin
                        seg_out_next  = seg_in;
                        digit_en_next = idx_onehot;
                        cnt_next      = '0;
                        state_next    = SHOW;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                SHOW: begin
                    seg_out_next  = seg_in;
                    digit_en_next = idx_onehot;
                    if (!hold) begin
                        if (cnt_reg == DWELL_LAST) begin
                            cnt_next      = '0;
                            seg_out_next  = '0;
                            digit_en_next = '0;
                            state_next    = BLANK;
                            if (idx_reg == IDX_LAST) begin
                                idx_next        = '0;
                                frame_tick_next = 1'b1;
                            end else begin
                                idx_next = idx_reg + 1'b1;
                            end
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next    = IDLE;
                    idx_next      = '0;
                    cnt_next      = '0;
                    seg_out_next  = '0;
                    digit_en_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            seg_out_reg    <= '0;
            digit_en_reg   <= '0;
            frame_tick_reg <= 1'b0;
        end else if (ena) begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            seg_out_reg    <= seg_out_next;
            digit_en_reg   <= digit_en_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign decod_sel  = idx_reg;
    assign seg_out    = seg_out_reg;
    assign digit_en   = digit_en_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a modelled nibble mux, hex decoder
// and reclock register (BLANK=2, DWELL=4, six digits: 36-cycle frame).
module tb_seg7_scan_driver;
    import seg7_scan_driver_pkg::*;

    logic       clk = 1'b0;
    logic       rst, ena, scan_en, hold;
    logic [7:0] seg_in;
    logic [2:0] decod_sel;
    logic [7:0] seg_out;
    logic [5:0] digit_en;
    logic       frame_tick;

    logic [7:0] a_cfg, b_cfg, f_cfg;
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int base  = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (6),
        .SEL_WIDTH   (3),
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .scan_en   (scan_en),
        .hold      (hold),
        .seg_in    (seg_in),
        .decod_sel (decod_sel),
        .seg_out   (seg_out),
        .digit_en  (digit_en),
        .frame_tick(frame_tick)
    );

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
            4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
            4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
            4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
        endcase
    endfunction

    function automatic logic [3:0] pick(input logic [2:0] s);
        case (s)
            SEL_A_LO: return a_cfg[3:0];
            SEL_A_HI: return a_cfg[7:4];
            SEL_B_LO: return b_cfg[3:0];
            SEL_B_HI: return b_cfg[7:4];
            SEL_F_LO: return f_cfg[3:0];
            SEL_F_HI: return f_cfg[7:4];
            default:  return 4'h0;
        endcase
    endfunction

    // Mux + decoder + reclock register in front of the driver.
    always @(posedge clk) seg_in <= hex7(pick(decod_sel));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; scan_en = 1'b0; hold = 1'b0;
        a_cfg = 8'h3C; b_cfg = 8'h71; f_cfg = 8'hE5;

        // Reset and idle
        step(); step();
        rst = 1'b0;
        chk("rst_sel", 32'(decod_sel), 32'd0);
        chk("rst_en", 32'(digit_en), 32'd0);
        chk("rst_seg", 32'(seg_out), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_all", {18'd0, frame_tick, decod_sel, digit_en, seg_out}, 32'd0);
        end
        $display("step: reset/idle done, %0d compared", n_cmp);

        // Two full frames of basic scanning; t counts edges since leaving IDLE
        scan_en = 1'b1;
        cyc = -1;
        for (int t = 0; t <= 72; t++) begin
            int ph;
            int d;
            logic [5:0] e_en;
            goto(t);
            ph   = t % 6;
            d    = (t / 6) % 6;
            e_en = (ph >= 2) ? (6'b000001 << d) : 6'b000000;
            chk("scan_sel", 32'(decod_sel), 32'(d));
            chk("scan_en", 32'(digit_en), 32'(e_en));
            chk("scan_seg", 32'(seg_out), (ph >= 2) ? 32'(hex7(pick(3'(d)))) : 32'd0);
            chk("scan_tick", 32'(frame_tick), (t > 0 && t % 36 == 0) ? 32'd1 : 32'd0);
            if (t == 3) chk("lat_d0_C", 32'(seg_out), 32'h39);
            if (t == 9) chk("lat_d1_3", 32'(seg_out), 32'h4F);
        end
        $display("step: basic scan done, %0d compared", n_cmp);

        // Change A mid-SHOW of digit 0: new pattern within 2 cycles
        goto(74);
        a_cfg = 8'h3D;
        goto(75);
        chk("chg_old", 32'(seg_out), 32'h39);
        goto(76);
        chk("chg_new", 32'(seg_out), 32'h5E);
        $display("step: live update done, %0d compared", n_cmp);

        // Hold digit 2 for 20 cycles
        goto(87);
        hold = 1'b1;
        for (int t = 88; t <= 107; t++) begin
            goto(t);
            chk("hold_en", 32'(digit_en), 32'h04);
            chk("hold_sel", 32'(decod_sel), 32'd2);
        end
        hold = 1'b0;
        goto(109);
        chk("hold_tail_en", 32'(digit_en), 32'h04);
        goto(110);
        chk("hold_end_en", 32'(digit_en), 32'h00);
        chk("hold_end_sel", 32'(decod_sel), 32'd3);
        goto(127);
        chk("hold_tick_pre", 32'(frame_tick), 32'd0);
        goto(128);
        chk("hold_tick", 32'(frame_tick), 32'd1);
        goto(129);
        chk("hold_tick_post", 32'(frame_tick), 32'd0);
        $display("step: hold done, %0d compared", n_cmp);

        // ena low for 10 cycles during BLANK of digit 1
        goto(134);
        ena = 1'b0;
        for (int t = 135; t <= 144; t++) begin
            goto(t);
            chk("frz_sel", 32'(decod_sel), 32'd1);
            chk("frz_en", 32'(digit_en), 32'd0);
            chk("frz_seg", 32'(seg_out), 32'd0);
        end
        ena = 1'b1;
        goto(145);
        chk("ena_blank", 32'(digit_en), 32'd0);
        goto(146);
        chk("ena_show_en", 32'(digit_en), 32'h02);
        chk("ena_show_seg", 32'(seg_out), 32'h4F);
        goto(173);
        chk("ena_tick_pre", 32'(frame_tick), 32'd0);
        goto(174);
        chk("ena_tick", 32'(frame_tick), 32'd1);

        // ena low while the tick is high: the pulse is held
        ena = 1'b0;
        for (int t = 175; t <= 177; t++) begin
            goto(t);
            chk("frz_tick", 32'(frame_tick), 32'd1);
        end
        ena = 1'b1;
        goto(178);
        chk("frz_tick_rel", 32'(frame_tick), 32'd0);
        $display("step: ena gating done, %0d compared", n_cmp);

        // Abort during SHOW of digit 4
        goto(204);
        chk("abort_pre_en", 32'(digit_en), 32'h10);
        chk("abort_pre_sel", 32'(decod_sel), 32'd4);
        scan_en = 1'b0;
        goto(205);
        chk("abort_en", 32'(digit_en), 32'd0);
        chk("abort_sel", 32'(decod_sel), 32'd0);
        chk("abort_seg", 32'(seg_out), 32'd0);
        for (int t = 205; t <= 215; t++) begin
            goto(t);
            chk("abort_no_tick", 32'(frame_tick), 32'd0);
        end

        // Restart: digit 0 first, tick 36 cycles later
        scan_en = 1'b1;
        base = 216;
        goto(base + 2);
        chk("restart_en", 32'(digit_en), 32'h01);
        chk("restart_sel", 32'(decod_sel), 32'd0);
        goto(base + 35);
        chk("restart_tick_pre", 32'(frame_tick), 32'd0);
        goto(base + 36);
        chk("restart_tick", 32'(frame_tick), 32'd1);
        $display("step: abort/restart done, %0d compared", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed display driver for the ALU front end. It sits around the existing nibble mux and 7-segment decoder: it generates decod_sel to walk the six nibbles (A lo/hi, B lo/hi, F lo/hi) and consumes the reclocked segment pattern. It drives shared segment lines plus one-hot digit enables, with a blanking gap between digits to suppress ghosting. A frame tick marks each full scan.

Parameters:
NUM_DIGITS, 6, number of digits scanned; sel codes 0..NUM_DIGITS-1.
SEL_WIDTH, 3, width of decod_sel; must satisfy 2**SEL_WIDTH >= NUM_DIGITS.
DWELL_CYCLES, 1024, clk cycles each digit is lit; must be >= 1.
BLANK_CYCLES, 4, clk cycles of blanking before each digit; must be >= 2 to cover the mux/decoder/reclock latency.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ena  input  1  global enable; when low, all state holds
scan_en  input  1  run scan; when low, display is off
hold  input  1  freeze on current digit; dwell count stops
seg_in  input  8  reclocked decoder output {dp,g,f,e,d,c,b,a}
decod_sel  output  SEL_WIDTH  nibble select to mux
seg_out  output  8  registered segment drive
digit_en  output  NUM_DIGITS  one-hot digit enable; bit i = sel code i
frame_tick  output  1  one-cycle pulse per completed frame

Behaviour:
- Everything is registered and the design is single-clock. Synchronous rst has priority over ena.
- Reset values: state IDLE, idx 0, counter 0, decod_sel 0, seg_out 0, digit_en 0, frame_tick 0.
- ena=0: no register changes. Outputs hold their values and any frame_tick in flight is held.
- FSM states: IDLE, BLANK, SHOW. decod_sel always equals idx.
- IDLE:
  - digit_en=0, seg_out=0.
  - If scan_en=1, go to BLANK with idx=0 and cnt=0.
- BLANK:
  - digit_en=0, seg_out=0; cnt increments each cycle.
  - On the cycle with cnt==BLANK_CYCLES-1: capture seg_in into seg_out, set digit_en[idx]=1, cnt=0, go to SHOW.
- SHOW:
  - digit_en is one-hot at idx; seg_out re-samples seg_in every cycle, so config changes appear with 1 cycle of added latency.
  - If hold=0, cnt increments. On cnt==DWELL_CYCLES-1:
    - cnt=0, digit_en=0, seg_out=0, go to BLANK.
    - idx increments; when idx==NUM_DIGITS-1 it wraps to 0 and frame_tick=1 for the next cycle only.
  - If hold=1, cnt freezes and the FSM stays in SHOW indefinitely.
- hold in IDLE or BLANK: no effect. It only applies once SHOW is reached.
- scan_en=0 in any state: next cycle goes to IDLE with idx=0, cnt=0, digit_en=0, seg_out=0, frame_tick=0. A partial frame produces no tick.
- Frame period with hold=0: NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. The first tick occurs that many cycles after leaving IDLE.
- Invariants: digit_en is never multi-hot. seg_out is nonzero only while digit_en is nonzero.
- Elaboration-time checks: fail if BLANK_CYCLES<2, DWELL_CYCLES<1, or 2**SEL_WIDTH<NUM_DIGITS.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, BLANK, SHOW};
  - localparams for the sel code map: 0=A_LO, 1=A_HI, 2=B_LO, 3=B_HI, 4=F_LO, 5=F_HI. The mux uses the same constants.
- No sub-module. One shared counter (width clog2 of max(DWELL_CYCLES, BLANK_CYCLES)) serves both phases, inline with the FSM.

Test Plan:
- Reset/IDLE: rst=1 for 2 cycles with scan_en=0 -> all outputs 0 and remain 0 for 50 cycles.
- Basic scan (NUM_DIGITS=6, BLANK=2, DWELL=4, model mux+decoder+reclock in bench), scan_en=1 -> decod_sel steps 0..5 every 6 cycles. digit_en walks 000001..100000, lit 4 cycles each. seg_out matches the decoded nibble while lit, 0 while blanked. frame_tick every 36 cycles, first at cycle 36.
- Latency: A=0x3C loaded via config regs -> digit 0 shows the pattern for 0xC, digit 1 the pattern for 0x3. Change A mid-SHOW -> seg_out updates within 2 cycles.
- hold: assert during SHOW of digit 2 for 20 cycles -> digit_en stays 000100 and decod_sel stays 2. After release, the remaining dwell completes and the next frame_tick is delayed by exactly 20 cycles.
- ena gating: ena=0 for 10 cycles mid-BLANK -> outputs frozen; after ena returns, the sequence resumes with the period extended by 10.
- Abort: scan_en=0 at digit 4 SHOW -> next cycle digit_en=0, decod_sel=0, no frame_tick. Re-enable -> scan restarts at digit 0, first tick after 36 cycles.
